// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply memory responder.
package mm_pkg;

    localparam int DW_DEF      = 20;
    localparam int OW_DEF      = 40;
    localparam int MAX_DIM_DEF = 4;

    typedef enum logic [1:0] {
        TGT_HDR  = 2'd0,
        TGT_A    = 2'd1,
        TGT_B    = 2'd2,
        TGT_RSVD = 2'd3
    } ld_tgt_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Header slots, addressed by ld_row on load and by i during the header phase.
    localparam logic [1:0] HDR_SLOT_ROW = 2'd0;
    localparam logic [1:0] HDR_SLOT_MID = 2'd1;
    localparam logic [1:0] HDR_SLOT_COL = 2'd2;

endpackage

// File: rtl/mm_mem_responder_if.sv
// Bus between the matrix-multiply initiator (master) and the memory responder (slave).
interface mm_mem_responder_if
    import mm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
);
    logic          mm_reset;
    logic [DW-1:0] i;
    logic [DW-1:0] j;
    logic          read;
    logic          write;
    logic          index;
    logic [DW-1:0] read_data;
    logic [OW-1:0] write_data;
    logic          finish;

    modport master (
        input  mm_reset, read_data,
        output i, j, read, write, index, write_data, finish
    );

    modport slave (
        output mm_reset, read_data,
        input  i, j, read, write, index, write_data, finish
    );
endinterface

// File: rtl/mm_mem_bank.sv
// MAX_DIM x MAX_DIM register array: synchronous write, combinational read; contents are not reset.
module mm_mem_bank #(
    parameter int W       = 20,
    parameter int MAX_DIM = 4,
    parameter int AW      = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_col_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_row_i,
    input  logic [AW-1:0] rd_col_i,
    output logic [W-1:0]  rd_data_o
);
    logic [W-1:0] mem_q [MAX_DIM][MAX_DIM];

    // Element write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_row_i][rd_col_i];
endmodule

// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matrix-multiply initiator: host load, zero-latency reads, result capture.
// Optional range checking of initiator reads is enabled by defining MM_MEM_BOUNDS_CHECK_EN.
module mm_mem_responder
    import mm_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int MAX_DIM = MAX_DIM_DEF,
    parameter int AW      = $clog2(MAX_DIM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [1:0]      ld_tgt,
    input  logic [AW-1:0]   ld_row,
    input  logic [AW-1:0]   ld_col,
    input  logic [DW-1:0]   ld_data,
    input  logic            start,
    mm_mem_responder_if.slave bus,
    input  logic [AW-1:0]   rd_row,
    input  logic [AW-1:0]   rd_col,
    output logic [OW-1:0]   rd_data,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2*AW:0]   wr_count
);
    localparam int CW = 2 * AW + 1;

    state_e        state_q, state_d;
    logic [DW-1:0] n_row_q, n_row_d;
    logic [DW-1:0] n_mid_q, n_mid_d;
    logic [DW-1:0] n_col_q, n_col_d;
    logic          err_q, err_d;
    logic [CW-1:0] wr_count_q, wr_count_d;
    logic [AW-1:0] wr_row_q, wr_row_d;
    logic [AW-1:0] wr_col_q, wr_col_d;

    logic          ld_en_s, a_we_s, b_we_s, c_we_s;
    logic [CW-1:0] elem_cnt_s;
    logic          full_s, capture_s, dims_bad_s, rd_err_s;
    logic [AW:0]   col_inc_s;
    logic [DW-1:0] a_rd_s, b_rd_s, read_data_s;

    function automatic logic dim_bad(input logic [DW-1:0] d);
        return (d == {DW{1'b0}}) || (d > DW'(MAX_DIM));
    endfunction

    // Dims are validated before SERVE, so only their low AW+1 bits matter for the element count.
    assign elem_cnt_s = {{AW{1'b0}}, n_row_q[AW:0]} * {{AW{1'b0}}, n_col_q[AW:0]};
    assign full_s     = (wr_count_q == elem_cnt_s);
    assign capture_s  = (state_q == ST_SERVE) && bus.write && !bus.read;
    assign dims_bad_s = dim_bad(n_row_q) || dim_bad(n_mid_q) || dim_bad(n_col_q);
    assign col_inc_s  = {1'b0, wr_col_q} + {{AW{1'b0}}, 1'b1};

    // Next-state logic: mode transitions, result-capture pointer and sticky error.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        ld_en_s    = 1'b0;
        c_we_s     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ld_en_s = ld_valid;
                if (start) begin
                    if (dims_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_SERVE;
                        err_d      = 1'b0;
                        wr_count_d = {CW{1'b0}};
                        wr_row_d   = {AW{1'b0}};
                        wr_col_d   = {AW{1'b0}};
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SERVE: begin
                if (capture_s && !full_s) begin
                    c_we_s     = 1'b1;
                    wr_count_d = wr_count_q + CW'(1'b1);
                    if (col_inc_s == n_col_q[AW:0]) begin
                        wr_col_d = {AW{1'b0}};
                        wr_row_d = wr_row_q + AW'(1'b1);
                    end else begin
                        wr_col_d = col_inc_s[AW-1:0];
                    end
                end else begin
                    c_we_s = 1'b0;
                end
                // The finish count check deliberately uses the post-capture count.
                err_d   = err_q | (capture_s && full_s) | rd_err_s
                        | (bus.finish && (wr_count_d != elem_cnt_s));
                state_d = bus.finish ? ST_DONE : ST_SERVE;
            end
            ST_DONE: begin
                if (ld_valid) begin
                    ld_en_s = 1'b1;
                    state_d = ST_LOAD;
                end else if (start) begin
                    state_d    = ST_SERVE;
                    err_d      = 1'b0;
                    wr_count_d = {CW{1'b0}};
                    wr_row_d   = {AW{1'b0}};
                    wr_col_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Host load decode: header slots and A/B write enables.
    always_comb begin
        n_row_d = n_row_q;
        n_mid_d = n_mid_q;
        n_col_d = n_col_q;
        a_we_s  = 1'b0;
        b_we_s  = 1'b0;
        if (ld_en_s) begin
            case (ld_tgt)
                TGT_HDR: begin
                    case (ld_row)
                        AW'(HDR_SLOT_ROW): n_row_d = ld_data;
                        AW'(HDR_SLOT_MID): n_mid_d = ld_data;
                        AW'(HDR_SLOT_COL): n_col_d = ld_data;
                        default:           n_row_d = n_row_q;
                    endcase
                end
                TGT_A:   a_we_s = 1'b1;
                TGT_B:   b_we_s = 1'b1;
                default: a_we_s = 1'b0;
            endcase
        end else begin
            a_we_s = 1'b0;
        end
    end

    // Zero-latency read response; index is only looked at outside the header phase.
    always_comb begin
        read_data_s = {DW{1'b0}};
        rd_err_s    = 1'b0;
        if ((state_q == ST_SERVE) && bus.read) begin
            if (bus.write) begin
                if (bus.i == DW'(HDR_SLOT_ROW)) begin
                    read_data_s = n_row_q;
                end else if (bus.i == DW'(HDR_SLOT_MID)) begin
                    read_data_s = n_mid_q;
                end else if (bus.i == DW'(HDR_SLOT_COL)) begin
                    read_data_s = n_col_q;
                end else begin
`ifdef MM_MEM_BOUNDS_CHECK_EN
                    rd_err_s = 1'b1;
`else
                    rd_err_s = 1'b0;
`endif
                end
            end else if (!bus.index) begin
`ifdef MM_MEM_BOUNDS_CHECK_EN
                if ((bus.i < n_row_q) && (bus.j < n_mid_q)) begin
                    read_data_s = a_rd_s;
                end else begin
                    rd_err_s = 1'b1;
                end
`else
                read_data_s = a_rd_s;
`endif
            end else begin
`ifdef MM_MEM_BOUNDS_CHECK_EN
                if ((bus.i < n_mid_q) && (bus.j < n_col_q)) begin
                    read_data_s = b_rd_s;
                end else begin
                    rd_err_s = 1'b1;
                end
`else
                read_data_s = b_rd_s;
`endif
            end
        end else begin
            rd_err_s = 1'b0;
        end
    end

`ifndef MM_MEM_BOUNDS_CHECK_EN
    // Without range checks the upper column-index bits have no effect (addresses wrap).
    logic unused_j_hi_s;
    assign unused_j_hi_s = ^bus.j[DW-1:AW];
`endif

    // State, header and capture-pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            err_q      <= 1'b0;
            wr_count_q <= {CW{1'b0}};
            wr_row_q   <= {AW{1'b0}};
            wr_col_q   <= {AW{1'b0}};
            n_row_q    <= {DW{1'b0}};
            n_mid_q    <= {DW{1'b0}};
            n_col_q    <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            n_row_q    <= n_row_d;
            n_mid_q    <= n_mid_d;
            n_col_q    <= n_col_d;
        end
    end

    mm_mem_bank #(.W(DW), .MAX_DIM(MAX_DIM), .AW(AW)) u_bank_a (
        .clk       (clk),
        .we_i      (a_we_s),
        .wr_row_i  (ld_row),
        .wr_col_i  (ld_col),
        .wr_data_i (ld_data),
        .rd_row_i  (bus.i[AW-1:0]),
        .rd_col_i  (bus.j[AW-1:0]),
        .rd_data_o (a_rd_s)
    );

    mm_mem_bank #(.W(DW), .MAX_DIM(MAX_DIM), .AW(AW)) u_bank_b (
        .clk       (clk),
        .we_i      (b_we_s),
        .wr_row_i  (ld_row),
        .wr_col_i  (ld_col),
        .wr_data_i (ld_data),
        .rd_row_i  (bus.i[AW-1:0]),
        .rd_col_i  (bus.j[AW-1:0]),
        .rd_data_o (b_rd_s)
    );

    mm_mem_bank #(.W(OW), .MAX_DIM(MAX_DIM), .AW(AW)) u_bank_c (
        .clk       (clk),
        .we_i      (c_we_s),
        .wr_row_i  (wr_row_q),
        .wr_col_i  (wr_col_q),
        .wr_data_i (bus.write_data),
        .rd_row_i  (rd_row),
        .rd_col_i  (rd_col),
        .rd_data_o (rd_data)
    );

    assign bus.read_data = read_data_s;
    assign bus.mm_reset  = (state_q != ST_SERVE);
    assign busy          = (state_q == ST_SERVE);
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;
    assign wr_count      = wr_count_q;
endmodule

// File: tb/tb_mm_mem_responder.sv
// Scoreboard bench for mm_mem_responder with a behavioural matrix-multiply initiator.
module tb_mm_mem_responder;
    import mm_pkg::*;

    localparam int DW = 20;
    localparam int OW = 40;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset, ld_valid, start;
    logic [1:0]    ld_tgt;
    logic [AW-1:0] ld_row, ld_col, rd_row, rd_col;
    logic [DW-1:0] ld_data;
    logic [OW-1:0] rd_data;
    logic          busy, done, err;
    logic [2*AW:0] wr_count;

    mm_mem_responder_if #(.DW(DW), .OW(OW)) bus ();

    mm_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_tgt   (ld_tgt),
        .ld_row   (ld_row),
        .ld_col   (ld_col),
        .ld_data  (ld_data),
        .start    (start),
        .bus      (bus),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ta [4][4];
    int tbm[4][4];
    int nr, nm, nc;
    logic [OW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.index      = 1'b0;
        bus.i          = {DW{1'b0}};
        bus.j          = {DW{1'b0}};
        bus.write_data = {OW{1'b0}};
        bus.finish     = 1'b0;
    endtask

    task automatic load(input logic [1:0] tgt, input int r, input int c, input int d);
        ld_valid = 1'b1;
        ld_tgt   = tgt;
        ld_row   = r[AW-1:0];
        ld_col   = c[AW-1:0];
        ld_data  = d[DW-1:0];
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic load_hdr(input int r, input int m, input int c);
        nr = r; nm = m; nc = c;
        load(TGT_HDR, 0, 0, r);
        load(TGT_HDR, 1, 0, m);
        load(TGT_HDR, 2, 0, c);
    endtask

    task automatic load_mats();
        for (int r = 0; r < nr; r++)
            for (int k = 0; k < nm; k++) load(TGT_A, r, k, ta[r][k]);
        for (int k = 0; k < nm; k++)
            for (int c = 0; c < nc; c++) load(TGT_B, k, c, tbm[k][c]);
    endtask

    // Reference product, row-major, pushed when a job is launched.
    task automatic push_expect();
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                longint s = 0;
                logic [63:0] sv;
                for (int k = 0; k < nm; k++) s += longint'(ta[r][k]) * longint'(tbm[k][c]);
                sv = s;
                exp_q.push_back(sv[OW-1:0]);
            end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_c();
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                rd_row = r[AW-1:0];
                rd_col = c[AW-1:0];
                #1;
                chk($sformatf("C[%0d][%0d]", r, c), rd_data, exp_q.pop_front());
            end
    endtask

    // Behavioural initiator: header phase, dot products via reads, row-major writes, finish.
    task automatic run_init(input int max_writes, input bit extra_write);
        int dn[3];
        int writes = 0;
        int tmp;
        logic [DW-1:0] ev;
        logic signed [OW-1:0] acc, ea, eb;
        for (int h = 0; h < 3; h++) begin
            bus.read = 1'b1; bus.write = 1'b1; bus.index = 1'bx; bus.i = DW'(h);
            #1;
            dn[h] = int'(bus.read_data);
            if (dn[h] > 4) dn[h] = 4;
            tick();
        end
        chk("hdr_row", 64'(dn[0]), 64'(nr));
        chk("hdr_mid", 64'(dn[1]), 64'(nm));
        chk("hdr_col", 64'(dn[2]), 64'(nc));
        for (int r = 0; r < dn[0]; r++)
            for (int c = 0; c < dn[2]; c++) begin
                acc = '0;
                for (int k = 0; k < dn[1]; k++) begin
                    bus.read = 1'b1; bus.write = 1'b0; bus.index = 1'b0;
                    bus.i = DW'(r); bus.j = DW'(k);
                    #1;
                    tmp = ta[r][k]; ev = tmp[DW-1:0];
                    chk("rd_a", bus.read_data, ev);
                    ea = {{(OW-DW){bus.read_data[DW-1]}}, bus.read_data};
                    tick();
                    bus.index = 1'b1; bus.i = DW'(k); bus.j = DW'(c);
                    #1;
                    tmp = tbm[k][c]; ev = tmp[DW-1:0];
                    chk("rd_b", bus.read_data, ev);
                    eb = {{(OW-DW){bus.read_data[DW-1]}}, bus.read_data};
                    tick();
                    acc = acc + ea * eb;
                end
                bus_idle();
                if (writes < max_writes) begin
                    bus.write = 1'b1; bus.write_data = acc;
                    tick();
                    writes++;
                    bus_idle();
                end
            end
        if (extra_write) begin
            bus.write = 1'b1; bus.write_data = 40'h12345;
            tick();
            bus_idle();
        end
        bus.finish = 1'b1;
        tick();
        bus_idle();
        for (int w = 0; w < 8 && !done; w++) tick();
        chk("done", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ld_valid = 1'b0; start = 1'b0;
        ld_tgt = 2'd0; ld_row = '0; ld_col = '0; ld_data = '0;
        rd_row = '0; rd_col = '0;
        bus_idle();
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mm_reset", bus.mm_reset, 1'b1);
        chk("rst_wr_count", wr_count, 5'd0);

        // 2x2 job
        ta[0][0] = 1; ta[0][1] = 2; ta[1][0] = 3; ta[1][1] = 4;
        tbm[0][0] = 5; tbm[0][1] = 6; tbm[1][0] = 7; tbm[1][1] = 8;
        load_hdr(2, 2, 2);
        load_mats();
        push_expect();
        pulse_start();
        chk("serve_busy", busy, 1'b1);
        chk("serve_mm_reset", bus.mm_reset, 1'b0);
        run_init(4, 1'b0);
        chk("j1_err", err, 1'b0);
        chk("j1_wr_count", wr_count, 5'd4);
        chk("j1_mm_reset", bus.mm_reset, 1'b1);
        check_c();

        // Signed 1x1 job; the first header load leaves DONE for LOAD
        ta[0][0] = -1; tbm[0][0] = -2;
        load_hdr(1, 1, 1);
        chk("ld_from_done", done, 1'b0);
        load_mats();
        push_expect();
        pulse_start();
        run_init(1, 1'b0);
        chk("j2_err", err, 1'b0);
        chk("j2_wr_count", wr_count, 5'd1);
        check_c();

        // Zero dimension rejected
        load_hdr(2, 0, 2);
        pulse_start();
        chk("dim0_err", err, 1'b1);
        chk("dim0_busy", busy, 1'b0);
        chk("dim0_mm_reset", bus.mm_reset, 1'b1);

        // Out-of-range A read, then reset mid-SERVE
        ta[0][0] = 1; ta[0][1] = 2; ta[1][0] = 3; ta[1][1] = 4;
        tbm[0][0] = 5; tbm[0][1] = 6; tbm[1][0] = 7; tbm[1][1] = 8;
        load_hdr(2, 2, 2);
        load_mats();
        load(TGT_A, 3, 1, 77);
        pulse_start();
        chk("dim_ok_err", err, 1'b0);
        bus.read = 1'b1; bus.index = 1'b0; bus.i = 20'd3; bus.j = 20'd1;
        #1;
`ifdef MM_MEM_BOUNDS_CHECK_EN
        chk("oob_data", bus.read_data, 20'd0);
        tick();
        chk("oob_err", err, 1'b1);
`else
        chk("oob_data", bus.read_data, 20'd77);
        tick();
        chk("oob_err", err, 1'b0);
`endif
        bus_idle();
        bus.write = 1'b1; bus.write_data = 40'd99;
        tick();
        bus_idle();
        chk("one_write", wr_count, 5'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_mm_reset", bus.mm_reset, 1'b1);
        chk("rst_mid_wr_count", wr_count, 5'd0);
        chk("rst_mid_err", err, 1'b0);

        // Reload header only; fifth write must be dropped
        load_hdr(2, 2, 2);
        push_expect();
        pulse_start();
        run_init(4, 1'b1);
        chk("ovf_err", err, 1'b1);
        chk("ovf_wr_count", wr_count, 5'd4);
        check_c();

        // Re-run from DONE clears err
        push_expect();
        pulse_start();
        chk("rerun_err", err, 1'b0);
        chk("rerun_busy", busy, 1'b1);
        chk("rerun_wr_count", wr_count, 5'd0);
        run_init(4, 1'b0);
        chk("rerun_err_end", err, 1'b0);
        chk("rerun_wr_count_end", wr_count, 5'd4);
        check_c();

        // Early finish after three results
        pulse_start();
        run_init(3, 1'b0);
        chk("early_err", err, 1'b1);
        chk("early_wr_count", wr_count, 5'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mm_mem_responder.md
Name: mm_mem_responder

Overview:
- Memory-side responder for the matrix-multiply initiator's `i`/`j`/`index`/`read`/`write` interface.
- Host side: loads the header (dims) and matrices A and B, then releases the initiator from reset.
- Serves zero-latency reads to the initiator, captures its 40-bit results into matrix C, and detects completion.
- Host reads back C after `done`.

Parameters:
- DW, 20, element/index width (matches initiator `i`, `j`, `read_data`).
- OW, 40, result width (matches `write_data`).
- MAX_DIM, 4, maximum rows/columns per matrix.
- AW, $clog2(MAX_DIM), internal row/col address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  host load strobe.
- ld_tgt  in  2  0=header, 1=A, 2=B, 3=reserved (ignored).
- ld_row  in  AW  row, or header slot 0..2 when ld_tgt=0.
- ld_col  in  AW  column.
- ld_data  in  DW  load value (signed for A/B).
- start  in  1  begin or re-run a multiply.
- mm_reset  out  1  reset driven to the initiator.
- i  in  DW  initiator row index.
- j  in  DW  initiator column index.
- read  in  1  initiator read.
- write  in  1  initiator write.
- index  in  1  0=A, 1=B.
- read_data  out  DW  combinational read response.
- write_data  in  OW  result from initiator.
- finish  in  1  initiator done.
- rd_row  in  AW  C readback row.
- rd_col  in  AW  C readback column.
- rd_data  out  OW  combinational C[rd_row][rd_col].
- busy  out  1  state==SERVE.
- done  out  1  state==DONE.
- err  out  1  sticky protocol/bounds error.
- wr_count  out  2*AW+1  results captured this run.

Behaviour:
- States: LOAD, SERVE, DONE.
- Reset values: state=LOAD, mm_reset=1, done=0, busy=0, err=0, wr_count=0, header regs (n_row, n_mid, n_col) = 0. A/B/C contents are not reset.
- LOAD:
  - ld_valid writes the target on the same edge.
  - Header slot 0=n_row, 1=n_mid, 2=n_col; slot 3 ignored.
  - start with any dim == 0 or > MAX_DIM: set err, stay in LOAD.
  - Otherwise: next state SERVE, wr_count<=0, err<=0.
- SERVE:
  - mm_reset=0.
  - read_data is combinational, zero latency.
  - read&write: header phase, `index` ignored (may be X). i=0 -> n_row, 1 -> n_mid, 2 -> n_col, else 0.
  - read&!write&!index: A[i][j]. Requires i<n_row, j<n_mid.
  - read&!write&index: B[i][j]. Requires i<n_mid, j<n_col.
  - Any other combination: read_data = 0.
  - Result capture on write&!read:
    - write_data is stored at C[wr_count / n_col][wr_count % n_col] (row-major arrival order).
    - i/j are ignored for writes.
    - wr_count increments each capture.
    - A capture when wr_count == n_row*n_col is dropped and sets err.
  - finish sampled high: next state DONE. If wr_count != n_row*n_col at that edge, err is also set.
  - A capture and finish on the same edge: the capture is taken first, and the count check uses the post-capture value.
  - ld_valid is ignored in SERVE.
- DONE:
  - mm_reset=1, done=1.
  - start: back to SERVE with wr_count and err cleared (re-run on the same A/B).
  - ld_valid: the load is performed and the state goes to LOAD.
  - start and ld_valid together: ld_valid wins.
- Reset mid-SERVE: immediate return to LOAD with mm_reset=1 on the next edge; C contents are undefined.
- Arithmetic: indices compare as unsigned DW; the element count n_row*n_col uses 2*AW+1 bits.

Optional Feature:
- MM_MEM_BOUNDS_CHECK_EN defined:
  - An out-of-range A/B read returns 0 and sets err.
  - A header read with i>2 sets err.
- Undefined:
  - No range checks; A/B reads use i[AW-1:0], j[AW-1:0] (wrap).
  - err is driven only by start-dim, overflow-capture and early-finish errors.

Decomposition:
- Package mm_pkg: DW/OW defaults, ld_tgt encodings (TGT_HDR, TGT_A, TGT_B), state enum, header slot constants.
- One natural sub-module, mm_mem_bank: a MAX_DIM x MAX_DIM register array with synchronous write and combinational read, parameterised width. Instanced three times (A and B at DW, C at OW).

Test Plan:
- Load header 2,2,2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; start with the initiator attached -> C=[[19,22],[43,50]], done=1, err=0, wr_count=4.
- Signed case: A=[[-1]], B=[[0xFFFFE(-2)]], dims 1,1,1 -> C[0][0]=40'd2, done after one capture.
- start with header n_mid=0 -> err=1, state stays LOAD, mm_reset stays 1.
- Model initiator: 5 writes on a 2x2 job -> fifth write dropped, err=1. Early finish after 3 writes -> DONE, err=1.
- With bounds check enabled: read with index=0, i=3 on a 2x2 job -> read_data=0, err=1. Without it -> returns A[3][j], err=0.
- Pulse reset during SERVE -> next cycle state=LOAD, mm_reset=1, wr_count=0. Then re-run from DONE via start -> same C, err cleared.
